// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl
// Divides the system clock into clk_out with an optional LFSR-driven jitter
// on every half-period. New settings arrive on a valid/ready port and are
// applied only on a falling transition of clk_out, so a high/low pair never
// mixes old and new settings.
//
// Ports:
//   clk             system clock, all logic on its rising edge
//   rst             synchronous active-high reset
//   cfg_valid       configuration request
//   cfg_ready       request accepted this cycle when high (low while a switch is pending)
//   cfg_half_period nominal half-period in clk cycles, 0 stops the output
//   cfg_jit         jitter exponent J, 0 disables jitter
//   cfg_done        one-cycle pulse when an accepted configuration takes effect
//   clk_out         generated clock (registered)
//   running         high while generating (RUN or SWITCH)
//   edge_cnt        rising edges of clk_out, wraps modulo 2^16
module clk_gen_ctrl #(
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half_period,
  input  logic [2:0]       cfg_jit,
  output logic             cfg_done,
  output logic             clk_out,
  output logic             running,
  output logic [15:0]      edge_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] act_half;
  logic [2:0]       act_jit;
  logic [CNT_W-1:0] pend_half;
  logic [2:0]       pend_jit;

  logic             xfer;
  logic [15:0]      lfsr_next;
  logic [CNT_W-1:0] eff_req;
  logic [CNT_W-1:0] eff_act;
  logic [CNT_W-1:0] eff_pend;

  // Effective half-period: half + (lf[J-1:0] - 2^(J-1)), evaluated signed with
  // two guard bits and clamped to [1, 2^CNT_W-1]. Only the low byte of the
  // LFSR can contribute since J <= 7 (needs CNT_W >= 6).
  function automatic logic [CNT_W-1:0] calc_eff(
    input logic [CNT_W-1:0] half,
    input logic [2:0]       jit,
    input logic [7:0]       lf
  );
    logic [7:0]              mask;
    logic [7:0]              bias;
    logic signed [CNT_W+1:0] raw_s;
    logic signed [CNT_W+1:0] bias_s;
    logic signed [CNT_W+1:0] sum;
    mask   = (8'd1 << jit) - 8'd1;
    bias   = (jit == 3'd0) ? 8'd0 : (8'd1 << (jit - 3'd1));
    raw_s  = '0;
    raw_s[7:0] = lf & mask;
    bias_s = '0;
    bias_s[7:0] = bias;
    sum = $signed({2'b00, half}) + raw_s - bias_s;
    if (sum < $signed((CNT_W+2)'(1)))
      calc_eff = CNT_ONE;
    else if (sum > $signed({2'b00, {CNT_W{1'b1}}}))
      calc_eff = '1;
    else
      calc_eff = sum[CNT_W-1:0];
  endfunction

  assign cfg_ready = (state != SWITCH);
  assign running   = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in shift-right form.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_comb begin
    eff_req  = calc_eff(cfg_half_period, cfg_jit, lfsr[7:0]);
    eff_act  = calc_eff(act_half, act_jit, lfsr[7:0]);
    eff_pend = calc_eff(pend_half, pend_jit, lfsr[7:0]);
  end

  // Every load of the phase counter consumes the current LFSR value and
  // advances it, so each phase gets its own jitter sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      clk_out   <= 1'b0;
      lfsr      <= LFSR_SEED;
      act_half  <= '0;
      act_jit   <= '0;
      pend_half <= '0;
      pend_jit  <= '0;
      cfg_done  <= 1'b0;
      edge_cnt  <= '0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          clk_out <= 1'b0;
          if (xfer) begin
            cfg_done <= 1'b1;
            if (cfg_half_period != '0) begin
              act_half <= cfg_half_period;
              act_jit  <= cfg_jit;
              cnt      <= eff_req - CNT_ONE;
              lfsr     <= lfsr_next;
              state    <= RUN;
            end
          end
        end
        RUN, SWITCH: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (state == SWITCH && clk_out) begin
            // Falling terminal count with a pending config: the low phase
            // that starts here already belongs to the new setting.
            clk_out  <= 1'b0;
            cfg_done <= 1'b1;
            if (pend_half != '0) begin
              act_half <= pend_half;
              act_jit  <= pend_jit;
              cnt      <= eff_pend - CNT_ONE;
              lfsr     <= lfsr_next;
              state    <= RUN;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end else begin
            clk_out <= ~clk_out;
            cnt     <= eff_act - CNT_ONE;
            lfsr    <= lfsr_next;
            if (!clk_out)
              edge_cnt <= edge_cnt + 16'd1;
          end
          // A request accepted in RUN only latches; a terminal count in the
          // same cycle above still used the old setting.
          if (state == RUN && cfg_valid) begin
            pend_half <= cfg_half_period;
            pend_jit  <= cfg_jit;
            state     <= SWITCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed testbench for clk_gen_ctrl: start-up, frequency switch, stop,
// jitter sequence against a reference LFSR, back-to-back requests and
// reset while a switch is pending.
module tb_clk_gen_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_half_period;
  logic [2:0]  cfg_jit;
  logic        cfg_done;
  logic        clk_out;
  logic        running;
  logic [15:0] edge_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  clk_gen_ctrl #(.CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_half_period (cfg_half_period),
    .cfg_jit         (cfg_jit),
    .cfg_done        (cfg_done),
    .clk_out         (clk_out),
    .running         (running),
    .edge_cnt        (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] lf);
    return {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
  endfunction

  function automatic int eff_model(input int half, input int j, input logic [15:0] lf);
    int lv;
    int e;
    lv = int'(lf);
    e  = half;
    if (j != 0) e = half + (lv % (1 << j)) - (1 << (j - 1));
    if (e < 1) e = 1;
    if (e > 65535) e = 65535;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns at the sample after it.
  task automatic send(input int half, input int j);
    cfg_half_period = 16'(half);
    cfg_jit         = 3'(j);
    cfg_valid       = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    $display("cfg half=%0d jit=%0d at cycle %0d ready_after=%0b", half, j, cyc, cfg_ready);
  endtask

  // Length in cycles of the clk_out phase that contains the current sample,
  // assuming the current sample is its first. Returns on the next phase's first sample.
  task automatic measure_run(output int len);
    logic v;
    v   = clk_out;
    len = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (clk_out !== v) return;
      len++;
    end
    checks++;
    errors++;
    $error("FAIL phase_timeout observed=%0d expected=<300", len);
  endtask

  initial begin
    int t0;
    int len;
    int mn;
    int mx;
    int nx;
    int nd;
    int cur;
    int nbad;
    logic take;
    logic [15:0] lf;

    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_half_period = '0;
    cfg_jit = '0;

    // Reset values
    do_reset();
    check("rst_clk_out", clk_out, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_done", cfg_done, 0);
    check("rst_running", running, 0);
    check("rst_edge_cnt", edge_cnt, 0);

    // Basic start: half=4, J=0
    send(4, 0);
    t0 = cyc;
    check("start_done", cfg_done, 1);
    check("start_running", running, 1);
    check("start_clk_low", clk_out, 0);
    goto_cyc(t0 + 1);  check("start_done_1cyc", cfg_done, 0);
    goto_cyc(t0 + 3);  check("start_low_end", clk_out, 0);
    goto_cyc(t0 + 4);  check("start_first_rise", clk_out, 1);
                       check("start_edge1", edge_cnt, 1);
    goto_cyc(t0 + 7);  check("start_high_end", clk_out, 1);
    goto_cyc(t0 + 8);  check("start_fall", clk_out, 0);
    goto_cyc(t0 + 12); check("start_rise2", clk_out, 1);
    goto_cyc(t0 + 80); check("start_edge_80", edge_cnt, 10);

    // Frequency switch 4 -> 2 requested on the first high cycle
    do_reset();
    send(4, 0);
    t0 = cyc;
    goto_cyc(t0 + 12); check("sw_high_at_req", clk_out, 1);
    send(2, 0);
    check("sw_ready_low", cfg_ready, 0);
    check("sw_running", running, 1);
    check("sw_done_wait", cfg_done, 0);
    goto_cyc(t0 + 15); check("sw_old_high_end", clk_out, 1);
                       check("sw_ready_still_low", cfg_ready, 0);
    goto_cyc(t0 + 16); check("sw_fall", clk_out, 0);
                       check("sw_done", cfg_done, 1);
                       check("sw_ready_back", cfg_ready, 1);
    goto_cyc(t0 + 17); check("sw_new_low", clk_out, 0);
                       check("sw_done_1cyc", cfg_done, 0);
    goto_cyc(t0 + 18); check("sw_new_rise", clk_out, 1);
    goto_cyc(t0 + 20); check("sw_new_fall", clk_out, 0);
    goto_cyc(t0 + 22); check("sw_new_rise2", clk_out, 1);
                       check("sw_edge_cnt", edge_cnt, 4);

    // Stop: IDLE request with half=0, then running half=3 stopped mid-low
    do_reset();
    send(0, 0);
    check("idle0_done", cfg_done, 1);
    check("idle0_running", running, 0);
    check("idle0_ready", cfg_ready, 1);
    @(negedge clk);
    check("idle0_done_1cyc", cfg_done, 0);
    send(3, 0);
    t0 = cyc;
    goto_cyc(t0 + 3);  check("stop_rise1", clk_out, 1);
    goto_cyc(t0 + 7);  check("stop_low_at_req", clk_out, 0);
    send(0, 0);
    check("stop_ready_low", cfg_ready, 0);
    goto_cyc(t0 + 9);  check("stop_last_rise", clk_out, 1);
    goto_cyc(t0 + 11); check("stop_last_high", clk_out, 1);
                       check("stop_still_running", running, 1);
    goto_cyc(t0 + 12); check("stop_clk_low", clk_out, 0);
                       check("stop_running", running, 0);
                       check("stop_done", cfg_done, 1);
                       check("stop_ready", cfg_ready, 1);
                       check("stop_edge_cnt", edge_cnt, 2);
    goto_cyc(t0 + 22); check("stop_held_low", clk_out, 0);
                       check("stop_done_1cyc", cfg_done, 0);
                       check("stop_edge_hold", edge_cnt, 2);

    // Jitter half=8, J=3 over 1000 phases against the reference LFSR
    do_reset();
    lf = 16'hACE1;
    send(8, 3);
    mn = 1000;
    mx = 0;
    for (int k = 0; k < 1000; k++) begin
      int exp_len;
      exp_len = eff_model(8, 3, lf);
      lf = lfsr_step(lf);
      measure_run(len);
      check("jit8_phase", len, exp_len);
      if (len < mn) mn = len;
      if (len > mx) mx = len;
    end
    check("jit8_min_ge4", (mn >= 4) ? 1 : 0, 1);
    check("jit8_max_le11", (mx <= 11) ? 1 : 0, 1);

    // Jitter half=1, J=3: clamped at one cycle minimum
    do_reset();
    lf = 16'hACE1;
    send(1, 3);
    nbad = 0;
    for (int k = 0; k < 100; k++) begin
      int exp_len;
      exp_len = eff_model(1, 3, lf);
      lf = lfsr_step(lf);
      measure_run(len);
      if (len < 1) nbad++;
      check("jit1_phase", len, exp_len);
    end
    check("jit1_short_phases", nbad, 0);

    // Back-to-back: cfg_valid held high, value alternates after each transfer
    do_reset();
    cur = 1;
    cfg_half_period = 16'd1;
    cfg_jit = 3'd0;
    cfg_valid = 1'b1;
    nx = 0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      take = cfg_ready;
      if (take) nx++;
      @(negedge clk);
      if (cfg_done) nd++;
      if (take) begin
        $display("b2b transfer half=%0d at cycle %0d", cur, cyc);
        cur = (cur == 1) ? 2 : 1;
        cfg_half_period = 16'(cur);
      end
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cfg_done) nd++;
    end
    check("b2b_transfers", nx, 6);
    check("b2b_dones", nd, 6);

    // Reset while a switch is pending
    do_reset();
    send(4, 0);
    t0 = cyc;
    goto_cyc(t0 + 5);  check("rsw_high", clk_out, 1);
    send(2, 0);
    check("rsw_in_switch", cfg_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rsw_clk_out", clk_out, 0);
    check("rsw_ready", cfg_ready, 1);
    check("rsw_done", cfg_done, 0);
    check("rsw_running", running, 0);
    check("rsw_edge_cnt", edge_cnt, 0);
    rst = 1'b0;
    nd = 0;
    nx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_done) nd++;
      if (running || clk_out) nx++;
    end
    check("rsw_no_done", nd, 0);
    check("rsw_stays_idle", nx, 0);
    lf = 16'hACE1;
    send(8, 3);
    for (int k = 0; k < 6; k++) begin
      int exp_len;
      exp_len = eff_model(8, 3, lf);
      lf = lfsr_step(lf);
      measure_run(len);
      check("rsw_seed_phase", len, exp_len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
